fp_vector_checker: RTL and testbench
====================================

Name: fp_vector_checker

Overview:
Synthesizable, on-chip stimulus/response engine for fpadd_single. It is the hardware counterpart of the simulation bench, so the adder can be self-tested on the Zedboard without a simulator.
- Fetches 96-bit {A, B, expected} vectors from an external synchronous ROM.
- Drives reg_A/reg_B, waits the adder latency, then compares the adder's out.
- Reports error count plus first-failure details.

Parameters:
NUM, 10, number of vectors in the ROM (>=1)
LATENCY, 2, adder latency: clock edges from reg_A/reg_B change to valid out (>=1)
IDX_W, $clog2(NUM)+1, width of index and error counters

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE
vec_addr  out  IDX_W  ROM address; registered
vec_data  in  96  ROM data, valid one cycle after vec_addr; [95:64]=A, [63:32]=B, [31:0]=expected
reg_A  out  32  operand A to the adder; registered
reg_B  out  32  operand B to the adder; registered
dut_out  in  32  adder result
busy  out  1  high while a run is in progress
done  out  1  high from run completion until the next start or reset
pass  out  1  valid while done; 1 iff err_count==0
err_count  out  IDX_W  number of mismatching vectors in the current or last run
first_err_valid  out  1  at least one mismatch captured
first_err_idx  out  IDX_W  index of the first mismatching vector
first_err_got  out  32  dut_out value at the first mismatch

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: every output is 0, state is IDLE, idx is 0, the wait counter is 0.
- Reset mid-run aborts immediately. The next cycle is IDLE with all outputs 0.
- FSM states: IDLE, FETCH, LOAD, WAIT, CHECK, DONE.
- IDLE: busy=0. On start: go to FETCH; idx<=0, vec_addr<=0; clear err_count, first_err_*, done, pass.
- FETCH: busy=1; vec_addr holds idx. Go to LOAD.
- LOAD:
  - reg_A<=vec_data[95:64], reg_B<=vec_data[63:32], exp_q<=vec_data[31:0].
  - wait counter <= LATENCY-1. Go to WAIT.
- WAIT: decrement the counter; leave for CHECK when it is 0. WAIT lasts exactly LATENCY cycles, so dut_out sampled in CHECK reflects LATENCY edges after the operands changed.
- CHECK: compare the full 32 bits, dut_out vs exp_q. No NaN/±0 equivalence.
  - On mismatch: err_count++.
  - If first_err_valid==0, capture first_err_idx<=idx, first_err_got<=dut_out, first_err_valid<=1.
  - If idx==NUM-1: go to DONE. Otherwise idx++, vec_addr<=idx+1, go to FETCH.
- DONE: busy=0, done=1, pass=(err_count==0). start restarts the run exactly as from IDLE.
- start while busy is ignored. start asserted on the same edge as reset loses to reset.
- Per-vector cost is LATENCY+3 cycles. A run takes NUM*(LATENCY+3) busy cycles: 50 for the defaults.
- reg_A/reg_B keep the last vector's operands after done. They are 0 only after reset.
- err_count cannot overflow: IDX_W holds NUM.

Decomposition:
- Shared package fp_test_pkg holds:
  - state enum
  - field offsets VEC_A_MSB=95, VEC_B_MSB=63, VEC_EXP_MSB=31; vector width VEC_W=96
  - common FP constants (FP_ONE=32'h3F800000)
- No sub-module inside this block. The vector ROM is a separate module, fp_vec_rom: a synchronous ROM initialised by $readmemh from fp_InOut.hex. It is instantiated beside this block and fpadd_single in the board top.

Test Plan:
1. Reset then start. Use a behavioural adder model with LATENCY=2 and NUM=1, vector {3F800000,3F800000,40000000}.
   -> busy for 5 cycles; done=1, pass=1, err_count=0, reg_A=3F800000.
2. NUM=3, with vector 1 expected 40400000 while the model returns 40000000.
   -> err_count=1, first_err_valid=1, first_err_idx=1, first_err_got=40000000, pass=0.
3. Model latency set to 3 with block LATENCY=2 over NUM=10 vectors.
   -> mismatches are flagged (err_count>0), proving the sample point is exactly LATENCY edges.
4. Assert reset during the WAIT of vector 4.
   -> next cycle: busy=0, err_count=0, reg_A=0, vec_addr=0. A fresh start runs all 10 vectors normally.
5. Pulse start while busy, then start again in DONE.
   -> the first pulse has no effect. The second clears err_count/first_err_* and reruns, with busy asserted the cycle after the pulse.
6. Vectors with +0/-0 (00000000 vs 80000000) and a NaN (7FC00000 vs 7FC00001).
   -> both count as errors under exact bit compare.

Source files
------------

// File: rtl/fp_test_pkg.sv
// Shared definitions for the on-chip fpadd_single self-test: FSM states,
// vector field layout and common single-precision constants.
package fp_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int FP_W        = 32;
  localparam int VEC_W       = 96;
  localparam int VEC_A_MSB   = 95;
  localparam int VEC_B_MSB   = 63;
  localparam int VEC_EXP_MSB = 31;

  localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;

endpackage

// File: rtl/fp_vector_checker.sv
// Stimulus/response engine: walks a ROM of {A, B, expected} vectors through
// the adder and records the error count plus the first failing vector.
module fp_vector_checker
  import fp_test_pkg::*;
#(
  parameter int NUM     = 10,
  parameter int LATENCY = 2,
  parameter int IDX_W   = $clog2(NUM) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IDX_W-1:0]  vec_addr,
  input  logic [VEC_W-1:0]  vec_data,
  output logic [FP_W-1:0]   reg_A,
  output logic [FP_W-1:0]   reg_B,
  input  logic [FP_W-1:0]   dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [FP_W-1:0]   first_err_got
);

  // LATENCY-1 is the largest value the wait counter ever holds
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LATENCY - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [FP_W-1:0]  exp_q;
  logic             mismatch;

  // Exact bit compare: no NaN or signed-zero equivalence
  assign mismatch = (dut_out != exp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      wait_cnt        <= '0;
      exp_q           <= '0;
      vec_addr        <= '0;
      reg_A           <= '0;
      reg_B           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_got   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_FETCH;
            idx             <= '0;
            vec_addr        <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_got   <= '0;
          end
        end
        // ROM registers vec_addr on this edge; data is usable in LOAD
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          reg_A    <= vec_data[VEC_A_MSB -: FP_W];
          reg_B    <= vec_data[VEC_B_MSB -: FP_W];
          exp_q    <= vec_data[VEC_EXP_MSB -: FP_W];
          wait_cnt <= WAIT_INIT;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_CHECK;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= idx;
              first_err_got   <= dut_out;
            end
          end
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            idx      <= idx + 1'b1;
            vec_addr <= idx + 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_vector_checker.sv
// Directed bench: three checker instances (NUM=1, 3, 10) each with a ROM and a
// behavioural adder whose latency can be stretched for the NUM=10 instance.
module tb_fp_vector_checker;
  import fp_test_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   model_lat = 2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [95:0] rom_1 [1];
  logic [95:0] rom_3 [4];
  logic [95:0] rom_10 [16];

  logic [0:0]  addr_1, err_1, fidx_1;
  logic [2:0]  addr_3, err_3, fidx_3;
  logic [4:0]  addr_10, err_10, fidx_10;
  logic [95:0] data_1, data_3, data_10;
  logic [31:0] ra_1, rb_1, out_1, fgot_1;
  logic [31:0] ra_3, rb_3, out_3, fgot_3;
  logic [31:0] ra_10, rb_10, out_10, fgot_10;
  logic        busy_1, done_1, pass_1, fev_1;
  logic        busy_3, done_3, pass_3, fev_3;
  logic        busy_10, done_10, pass_10, fev_10;
  logic [31:0] p1_1, p2_1, p1_3, p2_3, p1_10, p2_10, p3_10;

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {FP_ONE, FP_ONE}:             fadd = 32'h4000_0000;
      {FP_ONE, 32'h4000_0000}:      fadd = 32'h4040_0000;
      {32'h4000_0000, 32'h4000_0000}: fadd = 32'h4080_0000;
      {32'h4040_0000, FP_ONE}:      fadd = 32'h4080_0000;
      {32'h4080_0000, FP_ONE}:      fadd = 32'h40A0_0000;
      {32'h40A0_0000, FP_ONE}:      fadd = 32'h40C0_0000;
      {32'h0000_0000, 32'h0000_0000}: fadd = 32'h0000_0000;
      {32'h7FC0_0000, FP_ONE}:      fadd = 32'h7FC0_0000;
      default:                      fadd = a ^ b;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    data_1  <= rom_1[0];
    data_3  <= rom_3[addr_3[1:0]];
    data_10 <= rom_10[addr_10[3:0]];
    p1_1  <= fadd(ra_1, rb_1);   p2_1  <= p1_1;
    p1_3  <= fadd(ra_3, rb_3);   p2_3  <= p1_3;
    p1_10 <= fadd(ra_10, rb_10); p2_10 <= p1_10; p3_10 <= p2_10;
  end

  assign out_1  = p2_1;
  assign out_3  = p2_3;
  assign out_10 = (model_lat == 3) ? p3_10 : p2_10;

  fp_vector_checker #(.NUM(1), .LATENCY(2)) u_dut_1 (
    .clk(clk), .reset(reset), .start(start), .vec_addr(addr_1), .vec_data(data_1),
    .reg_A(ra_1), .reg_B(rb_1), .dut_out(out_1), .busy(busy_1), .done(done_1),
    .pass(pass_1), .err_count(err_1), .first_err_valid(fev_1),
    .first_err_idx(fidx_1), .first_err_got(fgot_1));

  fp_vector_checker #(.NUM(3), .LATENCY(2)) u_dut_3 (
    .clk(clk), .reset(reset), .start(start), .vec_addr(addr_3), .vec_data(data_3),
    .reg_A(ra_3), .reg_B(rb_3), .dut_out(out_3), .busy(busy_3), .done(done_3),
    .pass(pass_3), .err_count(err_3), .first_err_valid(fev_3),
    .first_err_idx(fidx_3), .first_err_got(fgot_3));

  fp_vector_checker #(.NUM(10), .LATENCY(2)) u_dut_10 (
    .clk(clk), .reset(reset), .start(start), .vec_addr(addr_10), .vec_data(data_10),
    .reg_A(ra_10), .reg_B(rb_10), .dut_out(out_10), .busy(busy_10), .done(done_10),
    .pass(pass_10), .err_count(err_10), .first_err_valid(fev_10),
    .first_err_idx(fidx_10), .first_err_got(fgot_10));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Counts busy cycles per instance until all are idle; bounded
  task automatic run_until_idle(output int c1, output int c3, output int c10);
    c1 = 0; c3 = 0; c10 = 0;
    for (int n = 0; n < 300; n++) begin
      if (!busy_1 && !busy_3 && !busy_10) return;
      c1 += int'(busy_1); c3 += int'(busy_3); c10 += int'(busy_10);
      tick();
    end
    checks++; errors++;
    $display("FAIL run_timeout: still busy after 300 cycles (want idle)");
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy_10, done_10, pass_10, fev_10, err_10, fidx_10, addr_10} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl10: got %b want 0",
               {busy_10, done_10, pass_10, fev_10, err_10, fidx_10, addr_10});
    end
    checks++;
    if ({ra_10, rb_10, fgot_10, ra_1, addr_1, busy_1, done_1} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {ra_10, rb_10, fgot_10, ra_1, addr_1, busy_1, done_1});
    end
  endtask

  task automatic test_single();
    int c1, c3, c10;
    pulse_start();
    run_until_idle(c1, c3, c10);
    checks++;
    if (c1 !== 5) begin errors++; $display("FAIL single_busy_cycles: got %0d want 5", c1); end
    checks++;
    if ({done_1, pass_1, err_1, fev_1} !== 4'b1100) begin
      errors++; $display("FAIL single_status: got %b want 1100", {done_1, pass_1, err_1, fev_1});
    end
    checks++;
    if (ra_1 !== 32'h3F80_0000) begin errors++; $display("FAIL single_reg_A: got %h want 3f800000", ra_1); end
    checks++;
    if (c10 !== 50) begin errors++; $display("FAIL ten_busy_cycles: got %0d want 50", c10); end
  endtask

  task automatic test_mismatch();
    int c1, c3, c10;
    pulse_start();
    run_until_idle(c1, c3, c10);
    checks++;
    if (err_3 !== 3'd1) begin errors++; $display("FAIL mm_err_count: got %0d want 1", err_3); end
    checks++;
    if ({fev_3, fidx_3} !== 4'b1001) begin
      errors++; $display("FAIL mm_first_idx: got v=%b idx=%0d want v=1 idx=1", fev_3, fidx_3);
    end
    checks++;
    if (fgot_3 !== 32'h4000_0000) begin errors++; $display("FAIL mm_first_got: got %h want 40000000", fgot_3); end
    checks++;
    if ({done_3, pass_3} !== 2'b10) begin errors++; $display("FAIL mm_pass: got %b want 10", {done_3, pass_3}); end
  endtask

  task automatic test_latency();
    int c1, c3, c10;
    model_lat = 3;
    do_reset();
    pulse_start();
    run_until_idle(c1, c3, c10);
    checks++;
    if (err_10 !== 5'd9) begin errors++; $display("FAIL lat_err_count: got %0d want 9", err_10); end
    checks++;
    if ({fev_10, fidx_10, fgot_10} !== {1'b1, 5'd0, 32'h0}) begin
      errors++; $display("FAIL lat_first: got v=%b idx=%0d got=%h want v=1 idx=0 got=0", fev_10, fidx_10, fgot_10);
    end
    checks++;
    if ({done_10, pass_10} !== 2'b10) begin errors++; $display("FAIL lat_pass: got %b want 10", {done_10, pass_10}); end
    model_lat = 2;
  endtask

  task automatic test_reset_mid_run();
    int c1, c3, c10;
    model_lat = 3;
    do_reset();
    pulse_start();
    for (int i = 0; i < 22; i++) tick();
    checks++;
    if ({busy_10, addr_10, err_10} !== {1'b1, 5'd4, 5'd3}) begin
      errors++; $display("FAIL mid_pre_reset: got busy=%b addr=%0d err=%0d want 1 4 3", busy_10, addr_10, err_10);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy_10, err_10, ra_10, addr_10, done_10} !== '0) begin
      errors++; $display("FAIL mid_post_reset: got busy=%b err=%0d A=%h addr=%0d done=%b want all 0",
                         busy_10, err_10, ra_10, addr_10, done_10);
    end
    model_lat = 2;
    pulse_start();
    run_until_idle(c1, c3, c10);
    checks++;
    if ({c10, err_10, done_10, pass_10} !== {32'd50, 5'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mid_rerun: got cycles=%0d err=%0d done=%b pass=%b want 50 0 1 1",
                         c10, err_10, done_10, pass_10);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c3, c10, cnt;
    model_lat = 3;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_10) break;
      cnt++;
      if (i == 10) start = 1'b1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (cnt !== 50) begin errors++; $display("FAIL b2b_ignored_start: got %0d busy cycles want 50", cnt); end
    checks++;
    if ({err_10, fgot_10} !== {5'd9, 32'h40A0_0000}) begin
      errors++; $display("FAIL b2b_errors: got err=%0d got=%h want 9 40a00000", err_10, fgot_10);
    end
    run_until_idle(c1, c3, c10);
    model_lat = 2;
    pulse_start();
    checks++;
    if ({busy_10, done_10, err_10, fev_10, fidx_10, fgot_10} !== {1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0}) begin
      errors++; $display("FAIL b2b_restart_clear: got busy=%b done=%b err=%0d v=%b idx=%0d got=%h want 1 0 0 0 0 0",
                         busy_10, done_10, err_10, fev_10, fidx_10, fgot_10);
    end
    run_until_idle(c1, c3, c10);
    checks++;
    if ({err_10, pass_10, done_10} !== {5'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL b2b_rerun: got err=%0d pass=%b done=%b want 0 1 1", err_10, pass_10, done_10);
    end
  endtask

  task automatic test_exact_compare();
    int c1, c3, c10;
    rom_3[0] = {32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
    rom_3[1] = {32'h7FC0_0000, FP_ONE, 32'h7FC0_0001};
    rom_3[2] = {FP_ONE, FP_ONE, 32'h4000_0000};
    pulse_start();
    run_until_idle(c1, c3, c10);
    checks++;
    if (err_3 !== 3'd2) begin errors++; $display("FAIL exact_err_count: got %0d want 2", err_3); end
    checks++;
    if ({fev_3, fidx_3, fgot_3, pass_3} !== {1'b1, 3'd0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL exact_first: got v=%b idx=%0d got=%h pass=%b want 1 0 0 0",
                         fev_3, fidx_3, fgot_3, pass_3);
    end
  endtask

  initial begin
    rom_1[0] = {FP_ONE, FP_ONE, 32'h4000_0000};
    for (int i = 0; i < 4; i++) rom_3[i] = '0;
    for (int i = 0; i < 16; i++) rom_10[i] = '0;
    rom_3[0] = {FP_ONE, FP_ONE, 32'h4000_0000};
    rom_3[1] = {FP_ONE, FP_ONE, 32'h4040_0000};
    rom_3[2] = {32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
    rom_10[0] = {FP_ONE, FP_ONE, 32'h4000_0000};
    rom_10[1] = {FP_ONE, 32'h4000_0000, 32'h4040_0000};
    rom_10[2] = {32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
    rom_10[3] = {32'h4040_0000, FP_ONE, 32'h4080_0000};
    rom_10[4] = {32'h4080_0000, FP_ONE, 32'h40A0_0000};
    rom_10[5] = {32'h40A0_0000, FP_ONE, 32'h40C0_0000};
    rom_10[6] = {FP_ONE, FP_ONE, 32'h4000_0000};
    rom_10[7] = {32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
    rom_10[8] = {FP_ONE, 32'h4000_0000, 32'h4040_0000};
    rom_10[9] = {32'h4080_0000, FP_ONE, 32'h40A0_0000};

    test_reset();
    test_single();
    test_mismatch();
    test_latency();
    test_reset_mid_run();
    test_back_to_back();
    test_exact_compare();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
